// File: rtl/seq_match_monitor_if.sv
// Bundle of control inputs and status outputs between the sequence detector
// monitor and its host logic.
interface seq_match_monitor_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
);
  logic             en;
  logic             match_in;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] thresh;
  logic             clr;
  logic             busy;
  logic             win_done;
  logic [CNT_W-1:0] win_result;
  logic [CNT_W-1:0] total_cnt;
  logic             alarm;

  modport master (
    output en, match_in, win_len, thresh, clr,
    input  busy, win_done, win_result, total_cnt, alarm
  );

  modport slave (
    input  en, match_in, win_len, thresh, clr,
    output busy, win_done, win_result, total_cnt, alarm
  );
endinterface

// File: rtl/seq_match_monitor.sv
// Counts rising edges of the detector match flag over programmable windows,
// reports per-window counts, a sticky threshold alarm and a saturating total.
module seq_match_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  seq_match_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, WINDOW} state_t;

  state_t           state, state_n;
  logic [WIN_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] wcnt, wcnt_n;
  logic [CNT_W-1:0] thresh_q, thresh_n;
  logic [CNT_W-1:0] win_result_n, total_n, final_c;
  logic             prev;
  logic             busy_n, win_done_n, alarm_n;
  logic             det_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign det_c   = mon.match_in & ~prev;
  assign final_c = det_c ? sat_inc(wcnt) : wcnt;

  // Next-state, window bookkeeping and status updates
  always_comb begin
    state_n      = state;
    timer_n      = timer;
    wcnt_n       = wcnt;
    thresh_n     = thresh_q;
    win_done_n   = 1'b0;
    win_result_n = mon.clr ? '0 : mon.win_result;
    alarm_n      = mon.clr ? 1'b0 : mon.alarm;
    total_n      = mon.clr ? '0 : mon.total_cnt;
    if (mon.en && det_c) total_n = sat_inc(total_n);

    case (state)
      IDLE: begin
        if (mon.en && (mon.win_len != '0)) begin
          state_n  = WINDOW;
          timer_n  = mon.win_len;
          wcnt_n   = '0;
          thresh_n = mon.thresh;
        end
      end
      WINDOW: begin
        if (!mon.en) begin
          state_n = IDLE;
          timer_n = '0;
          wcnt_n  = '0;
        end else if (timer > WIN_W'(1)) begin
          timer_n = timer - WIN_W'(1);
          wcnt_n  = final_c;
        end else begin
          // Last window cycle: publish, then restart with no gap cycle
          win_result_n = final_c;
          win_done_n   = 1'b1;
          if ((thresh_q != '0) && (final_c >= thresh_q)) alarm_n = 1'b1;
          wcnt_n = '0;
          if (mon.win_len != '0) begin
            timer_n  = mon.win_len;
            thresh_n = mon.thresh;
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == WINDOW);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= '0;
      wcnt           <= '0;
      thresh_q       <= '0;
      prev           <= 1'b0;
      mon.busy       <= 1'b0;
      mon.win_done   <= 1'b0;
      mon.win_result <= '0;
      mon.total_cnt  <= '0;
      mon.alarm      <= 1'b0;
    end else begin
      state          <= state_n;
      timer          <= timer_n;
      wcnt           <= wcnt_n;
      thresh_q       <= thresh_n;
      prev           <= mon.match_in;
      mon.busy       <= busy_n;
      mon.win_done   <= win_done_n;
      mon.win_result <= win_result_n;
      mon.total_cnt  <= total_n;
      mon.alarm      <= alarm_n;
    end
  end

endmodule

// File: tb/tb_seq_match_monitor.sv
// Directed, table-driven bench for seq_match_monitor with hand-computed
// expectations plus hand-written back-to-back and saturation sequences.
module tb_seq_match_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 16;

  typedef struct {
    logic             rst;
    logic             en;
    logic             m;
    logic [WIN_W-1:0] len;
    logic [CNT_W-1:0] th;
    logic             clr;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] res;
    logic [CNT_W-1:0] tot;
    logic             al;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_miss = 0;
  vec_t tbl[$];

  seq_match_monitor_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

  seq_match_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic en, input logic m,
                              input int len, input int th, input logic clr,
                              input logic busy, input logic done, input int res,
                              input int tot, input logic al);
    vec_t v;
    v.rst = r; v.en = en; v.m = m; v.len = WIN_W'(len); v.th = CNT_W'(th); v.clr = clr;
    v.busy = busy; v.done = done; v.res = CNT_W'(res); v.tot = CNT_W'(tot); v.al = al;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic step(input logic r, input logic en, input logic m,
                      input int len, input int th, input logic clr);
    rst          = r;
    bus.en       = en;
    bus.match_in = m;
    bus.win_len  = WIN_W'(len);
    bus.thresh   = CNT_W'(th);
    bus.clr      = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seen_done;
    logic m;

    bus.en = 1'b0; bus.match_in = 1'b0; bus.win_len = '0; bus.thresh = '0; bus.clr = 1'b0;

    // Reset, then reset asserted mid-window
    add(1,0,0, 0,0,0, 0,0,0,0,0);
    add(0,1,0,10,1,0, 1,0,0,0,0);
    add(0,1,0,10,1,0, 1,0,0,0,0);
    add(0,1,1,10,1,0, 1,0,0,1,0);
    add(0,1,0,10,1,0, 1,0,0,1,0);
    add(0,1,1,10,1,0, 1,0,0,2,0);
    add(1,1,0,10,1,0, 0,0,0,0,0);
    for (int i = 0; i < 12; i++) add(0,0,0,10,1,0, 0,0,0,0,0);

    // Threshold hit: pulses at window cycles 1 and 4
    add(0,1,0,8,2,0, 1,0,0,0,0);
    add(0,1,1,8,2,0, 1,0,0,1,0);
    add(0,1,0,8,2,0, 1,0,0,1,0);
    add(0,1,0,8,2,0, 1,0,0,1,0);
    add(0,1,1,8,2,0, 1,0,0,2,0);
    add(0,1,0,8,2,0, 1,0,0,2,0);
    add(0,1,0,8,2,0, 1,0,0,2,0);
    add(0,1,0,8,2,0, 1,0,0,2,0);
    add(0,1,0,8,2,0, 1,1,2,2,1);
    add(0,0,0,8,2,0, 0,0,2,2,1);
    add(0,0,0,8,2,1, 0,0,0,0,0);

    // Held level over window cycles 3-6 counts once
    add(0,1,0,8,2,0, 1,0,0,0,0);
    add(0,1,0,8,2,0, 1,0,0,0,0);
    add(0,1,0,8,2,0, 1,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,1,1,8,2,0, 1,0,0,1,0);
    add(0,1,0,8,2,0, 1,0,0,1,0);
    add(0,1,0,8,2,0, 1,1,1,1,0);
    add(0,0,0,8,2,0, 0,0,1,1,0);

    // Idle counting, clr with coincident edge, no count with en=0
    add(0,1,1,0,2,0, 0,0,1,2,0);
    add(0,1,0,0,2,0, 0,0,1,2,0);
    add(0,1,1,0,2,1, 0,0,0,1,0);
    add(0,0,0,0,2,0, 0,0,0,1,0);
    add(0,0,1,0,2,0, 0,0,0,1,0);

    // clr coincident with alarm set and completion (final=3, thresh=3)
    add(0,1,0,6,3,0, 1,0,0,1,0);
    add(0,1,1,6,3,0, 1,0,0,2,0);
    add(0,1,0,6,3,0, 1,0,0,2,0);
    add(0,1,1,6,3,0, 1,0,0,3,0);
    add(0,1,0,6,3,0, 1,0,0,3,0);
    add(0,1,1,6,3,0, 1,0,0,4,0);
    add(0,1,0,6,3,1, 1,1,3,0,1);
    add(0,0,0,6,3,1, 0,0,0,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].m, int'(tbl[i].len), int'(tbl[i].th), tbl[i].clr);
      chk("busy",       i, int'(bus.busy),       int'(tbl[i].busy));
      chk("win_done",   i, int'(bus.win_done),   int'(tbl[i].done));
      chk("win_result", i, int'(bus.win_result), int'(tbl[i].res));
      chk("total_cnt",  i, int'(bus.total_cnt),  int'(tbl[i].tot));
      chk("alarm",      i, int'(bus.alarm),      int'(tbl[i].al));
    end

    // Back-to-back windows of 4: edges at cycles 4 (last of w1), 6, 9 (first of w3)
    step(0,1,0,4,0,0);
    chk("b2b_start_busy", 0, int'(bus.busy), 1);
    for (int k = 1; k <= 12; k++) begin
      m = (k == 4) || (k == 6) || (k == 9);
      step(0,1,m,4,0,0);
      chk("b2b_busy", k, int'(bus.busy), 1);
      chk("b2b_done", k, int'(bus.win_done), int'(k % 4 == 0));
      if (k % 4 == 0) chk("b2b_result", k, int'(bus.win_result), 1);
    end
    chk("b2b_total", 0, int'(bus.total_cnt), 3);
    chk("b2b_alarm", 0, int'(bus.alarm), 0);
    step(0,0,0,4,0,0);
    chk("b2b_abort_busy", 0, int'(bus.busy), 0);
    chk("b2b_abort_done", 0, int'(bus.win_done), 0);

    // Saturation of total_cnt, then abort mid-window
    step(0,1,0,1000,0,0);
    seen_done = 0;
    for (int i = 0; i < 600; i++) begin
      step(0,1,(i % 2 == 0),1000,0,0);
      if (bus.win_done) seen_done++;
    end
    chk("sat_total", 0, int'(bus.total_cnt), 255);
    chk("sat_no_done", 0, seen_done, 0);
    chk("sat_busy", 0, int'(bus.busy), 1);
    step(0,0,0,1000,0,0);
    chk("sat_abort_busy", 0, int'(bus.busy), 0);
    chk("sat_abort_done", 0, int'(bus.win_done), 0);
    chk("sat_abort_result", 0, int'(bus.win_result), 1);
    step(0,1,1,0,0,0);
    chk("sat_no_wrap", 0, int'(bus.total_cnt), 255);
    step(0,0,0,0,0,0);
    chk("sat_idle_done", 0, int'(bus.win_done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end

endmodule
